// File: rtl/tile_pkg.sv
// Shared state encoding, screen geometry and reset patterns for the tile game controller.
package tile_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t WAIT_TICK = 3'd1;
  localparam state_t UPDATE    = 3'd2;
  localparam state_t REQ       = 3'd3;
  localparam state_t WAIT_DONE = 3'd4;
  localparam state_t OVER      = 3'd5;

  // Lane of tile i sits in bits [2i+1:2i]: tiles start in lanes 0,2,1,3.
  localparam logic [7:0] RESET_LANES = {2'd3, 2'd1, 2'd2, 2'd0};
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances only while en is high.
module lfsr8
  import tile_pkg::*;
(
  input  logic       clock,
  input  logic       res,
  input  logic       en,
  output logic [1:0] rnd
);

  logic [7:0] q;

  always_ff @(posedge clock) begin
    if (res) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

  assign rnd = q[1:0];

endmodule

// File: rtl/tile_controller.sv
// Game logic for four falling tiles: frame-tick movement, go/done redraw handshake, key judging, score.
// Optional macro TILE_SPEEDUP_EN: the fall step grows by one per eight hits, capped at 4 pixels.
module tile_controller
  import tile_pkg::*;
#(
  parameter int FRAME_DIV = 833333,
  parameter int LANE_W    = SCREEN_W / 4,
  parameter int SPACING   = 30,
  parameter int HIT_Y     = 88,
  parameter int BOTTOM_Y  = SCREEN_H - 16,
  parameter int STEP      = 1
)(
  input  logic       clock,
  input  logic       res,
  input  logic       start,
  input  logic [3:0] key,
  input  logic       done,
  output logic       go,
  output logic [7:0] x1,
  output logic [7:0] x2,
  output logic [7:0] x3,
  output logic [7:0] x4,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [7:0] y4,
  output logic [7:0] score,
  output logic       gd
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic signed [7:0] HIT_LIM    = 8'(HIT_Y);
  localparam logic signed [7:0] BOTTOM_LIM = 8'(BOTTOM_Y);

  state_t        state;
  logic [1:0]    head;
  logic [1:0]    lane [4];
  logic [7:0]    y [4];
  logic [CW-1:0] fcnt;
  logic [7:0]    step;
  logic [7:0]    head_next_y;
  logic [1:0]    rnd;
  logic          tick;
  logic          hit;
  logic          hit_en;

  assign tick        = (fcnt == CW'(FRAME_DIV - 1));
  assign hit         = (key == (4'b0001 << lane[head])) && ($signed(y[head]) >= HIT_LIM);
  assign hit_en      = (state == WAIT_TICK) && hit;
  assign head_next_y = y[head] + step;

  lfsr8 u_lfsr (
    .clock (clock),
    .res   (res),
    .en    (hit_en),
    .rnd   (rnd)
  );

`ifdef TILE_SPEEDUP_EN
  logic [7:0] hit_count;
  logic [5:0] boost;

  always_ff @(posedge clock) begin
    if (res) begin
      hit_count <= 8'd0;
    end else if (hit_en && hit_count != 8'hFF) begin
      hit_count <= hit_count + 8'd1;
    end
  end

  always_comb begin
    boost = 6'(STEP) + {1'b0, hit_count[7:3]};
    step  = (boost > 6'd4) ? 8'd4 : {2'b00, boost};
  end
`else
  assign step = 8'(STEP);
`endif

  // Free-running frame divider; frozen while idle or after the game ends.
  always_ff @(posedge clock) begin
    if (res) begin
      fcnt <= '0;
    end else if (state != IDLE && state != OVER) begin
      fcnt <= tick ? '0 : fcnt + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (res) begin
      state <= IDLE;
      head  <= 2'd0;
      go    <= 1'b0;
      gd    <= 1'b0;
      score <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        lane[i] <= RESET_LANES[2*i +: 2];
        y[i]    <= 8'(-(i * SPACING));
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= REQ;
        end
        WAIT_TICK: begin
          // A key landing on the tick cycle is judged first; the move follows next cycle.
          if (key != 4'b0000) begin
            if (hit) begin
              if (score != 8'hFF) score <= score + 8'd1;
              y[head]    <= y[head - 2'd1] - 8'(SPACING);
              lane[head] <= rnd;
              head       <= head + 2'd1;
              if (tick) state <= UPDATE;
            end else begin
              state <= OVER;
              gd    <= 1'b1;
            end
          end else if (tick) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 4; i++) y[i] <= y[i] + step;
          if ($signed(head_next_y) > BOTTOM_LIM) begin
            state <= OVER;
            gd    <= 1'b1;
          end else begin
            state <= REQ;
          end
        end
        REQ: begin
          go    <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            go    <= 1'b0;
            state <= WAIT_TICK;
          end
        end
        OVER: begin
          go <= 1'b0;
        end
        default: begin
          state <= IDLE;
          go    <= 1'b0;
        end
      endcase
    end
  end

  assign x1 = 8'(int'(lane[0]) * LANE_W);
  assign x2 = 8'(int'(lane[1]) * LANE_W);
  assign x3 = 8'(int'(lane[2]) * LANE_W);
  assign x4 = 8'(int'(lane[3]) * LANE_W);
  assign y1 = y[0];
  assign y2 = y[1];
  assign y3 = y[2];
  assign y4 = y[3];

endmodule
